chord_song_reader: RTL

Sequencer that drives the four-voice chord notes player. It walks one song stored in an external synchronous song ROM and issues one chord per entry: four notes, a shared duration, a voice count and timbre metadata, presented with a `load_new_note` pulse. It waits for the player's `done_with_note` handshake before advancing, and supports pause (`play` low) and end-of-song detection. It sits between the top-level controls and the notes player.

---
 rtl/chord_song_reader_if.sv | 28 ++
 rtl/chord_song_reader.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/chord_song_reader_if.sv
// Player-side bundle between the song reader and the four-voice notes player.
// The reader drives one chord (four notes, duration, voice count, timbre) plus
// a one-cycle load pulse, and the player reports back with done_with_note.
interface chord_song_reader_if;
    logic [5:0] note1;
    logic [5:0] note2;
    logic [5:0] note3;
    logic [5:0] note4;
    logic [5:0] duration;
    logic [1:0] num_notes;
    logic [2:0] metadata;
    logic       load_new_note;
    logic       done_with_note;

    modport master (
        output note1, note2, note3, note4,
        output duration, num_notes, metadata,
        output load_new_note,
        input  done_with_note
    );

    modport slave (
        input  note1, note2, note3, note4,
        input  duration, num_notes, metadata,
        input  load_new_note,
        output done_with_note
    );
endinterface

// File: rtl/chord_song_reader.sv
// Walks one song in an external synchronous ROM and hands each chord entry to
// the notes player, waiting for the player's done handshake between chords.
// Entries with zero duration are skipped, an end flag or the last index stops
// the song, and play low freezes everything outside IDLE and DONE.
module chord_song_reader #(
    parameter int INDEX_BITS = 5,
    parameter int SONG_BITS  = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            play,
    input  logic [SONG_BITS-1:0]            song,
    output logic [SONG_BITS+INDEX_BITS-1:0] rom_addr,
    input  logic [35:0]                     rom_data,
    chord_song_reader_if.master             player,
    output logic                            play_enable,
    output logic                            song_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_LOAD,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                          state_q, state_d;
    logic [INDEX_BITS-1:0]           index_q, index_d;
    logic [INDEX_BITS-1:0]           index_inc;
    logic [SONG_BITS-1:0]            song_q, song_d;
    logic [SONG_BITS+INDEX_BITS-1:0] rom_addr_q, rom_addr_d;
    logic [5:0]                      note1_q, note1_d;
    logic [5:0]                      note2_q, note2_d;
    logic [5:0]                      note3_q, note3_d;
    logic [5:0]                      note4_q, note4_d;
    logic [5:0]                      duration_q, duration_d;
    logic [1:0]                      num_notes_q, num_notes_d;
    logic [2:0]                      metadata_q, metadata_d;

    assign index_inc = index_q + INDEX_BITS'(1);

    // State, position and chord registers; reset clears every visible output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            song_q      <= '0;
            rom_addr_q  <= '0;
            note1_q     <= '0;
            note2_q     <= '0;
            note3_q     <= '0;
            note4_q     <= '0;
            duration_q  <= '0;
            num_notes_q <= '0;
            metadata_q  <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            song_q      <= song_d;
            rom_addr_q  <= rom_addr_d;
            note1_q     <= note1_d;
            note2_q     <= note2_d;
            note3_q     <= note3_d;
            note4_q     <= note4_d;
            duration_q  <= duration_d;
            num_notes_q <= num_notes_d;
            metadata_q  <= metadata_d;
        end
    end

    // Next-state logic: every running state holds still while play is low.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        song_d      = song_q;
        rom_addr_d  = rom_addr_q;
        note1_d     = note1_q;
        note2_d     = note2_q;
        note3_d     = note3_q;
        note4_d     = note4_q;
        duration_d  = duration_q;
        num_notes_d = num_notes_q;
        metadata_d  = metadata_q;

        case (state_q)
            S_IDLE: begin
                index_d    = '0;
                rom_addr_d = {song, {INDEX_BITS{1'b0}}};
                if (play) begin
                    song_d  = song;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (play) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (play) begin
                    if (rom_data[35]) begin
                        state_d = S_DONE;
                    end else if (rom_data[10:5] == 6'd0) begin
                        state_d = S_NEXT;
                    end else begin
                        note1_d     = rom_data[34:29];
                        note2_d     = rom_data[28:23];
                        note3_d     = rom_data[22:17];
                        note4_d     = rom_data[16:11];
                        duration_d  = rom_data[10:5];
                        num_notes_d = rom_data[4:3];
                        metadata_d  = rom_data[2:0];
                        state_d     = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (play) state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (play && !player.done_with_note) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (play && player.done_with_note) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (play) begin
                    if (index_q == {INDEX_BITS{1'b1}}) begin
                        state_d = S_DONE;
                    end else begin
                        index_d    = index_inc;
                        rom_addr_d = {song_q, index_inc};
                        state_d    = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                if (!play) begin
                    index_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rom_addr               = rom_addr_q;
    assign player.note1           = note1_q;
    assign player.note2           = note2_q;
    assign player.note3           = note3_q;
    assign player.note4           = note4_q;
    assign player.duration        = duration_q;
    assign player.num_notes       = num_notes_q;
    assign player.metadata        = metadata_q;
    assign player.load_new_note   = (state_q == S_LOAD) && play;
    assign play_enable            = play && (state_q != S_IDLE) && (state_q != S_DONE);
    assign song_done              = (state_q == S_DONE);

endmodule
